// File: rtl/calc_sched.sv
// Two-requester round-robin scheduler around a shared combinational calculator.
// Optional build macro CALC_SCHED_SAT_EN saturates overflowing results.
module calc_sched #(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [2:0]          req0_op,
  input  logic signed [W-1:0] req0_a,
  input  logic signed [W-1:0] req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [2:0]          req1_op,
  input  logic signed [W-1:0] req1_a,
  input  logic signed [W-1:0] req1_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic signed [W-1:0] rsp_r,
  output logic                rsp_ovf,
  output logic [CNT_W-1:0]    ovf_cnt,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [2:0]          op_q, op_d;
  logic signed [W-1:0] a_q, a_d, b_q, b_d;
  logic                id_q, id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic signed [W-1:0] rsp_r_q, rsp_r_d;
  logic                rsp_ovf_q, rsp_ovf_d;
  logic [CNT_W-1:0]    ovf_cnt_q, ovf_cnt_d;
  logic                grant0_s, grant1_s;
  logic signed [W-1:0] calc_r_s, res_r_s;
  logic                calc_ovf_s;

  // Shared datapath: returns {ovf, r}; |min| wraps to min and flags overflow.
  function automatic logic [W:0] comb_calc(input logic [2:0] op,
                                           input logic signed [W-1:0] a,
                                           input logic signed [W-1:0] b);
    logic signed [W-1:0] r;
    logic                ovf;
    r   = '0;
    ovf = 1'b0;
    case (op)
      3'b000, 3'b100: begin
        r   = a + b;
        ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b001: begin
        r   = a - b;
        ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b101: begin
        r   = b - a;
        ovf = (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]);
      end
      3'b010, 3'b011: begin
        r   = b[W-1] ? -b : b;
        ovf = b[W-1] && r[W-1];
      end
      3'b110, 3'b111: begin
        r   = a[W-1] ? -a : a;
        ovf = a[W-1] && r[W-1];
      end
      default: begin
        r   = '0;
        ovf = 1'b0;
      end
    endcase
    return {ovf, r};
  endfunction

  assign {calc_ovf_s, calc_r_s} = comb_calc(op_q, a_q, b_q);

`ifdef CALC_SCHED_SAT_EN
  localparam logic signed [W-1:0] MAX_S = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_S = {1'b1, {(W-1){1'b0}}};
  assign res_r_s = calc_ovf_s ? (calc_r_s[W-1] ? MAX_S : MIN_S) : calc_r_s;
`else
  assign res_r_s = calc_r_s;
`endif

  // Round-robin grant, only offered while idle; ties go away from last_grant.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_q == IDLE) begin
      grant0_s = req0_valid && (!req1_valid || last_grant_q);
      grant1_s = req1_valid && (!req0_valid || !last_grant_q);
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Next-state and register updates for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_r_d      = rsp_r_q;
    rsp_ovf_d    = rsp_ovf_q;
    ovf_cnt_d    = ovf_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant0_s || grant1_s) begin
          op_d         = grant1_s ? req1_op : req0_op;
          a_d          = grant1_s ? req1_a  : req0_a;
          b_d          = grant1_s ? req1_b  : req0_b;
          id_d         = grant1_s;
          last_grant_d = grant1_s;
          state_d      = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_r_d     = res_r_s;
        rsp_ovf_d   = calc_ovf_s;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_ovf_q && (ovf_cnt_q != {CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            ovf_cnt_d = ovf_cnt_q;
          end
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= 3'b000;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_r_q      <= '0;
      rsp_ovf_q    <= 1'b0;
      ovf_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_r_q      <= rsp_r_d;
      rsp_ovf_q    <= rsp_ovf_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_r      = rsp_r_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign ovf_cnt    = ovf_cnt_q;
  assign busy       = (state_q != IDLE);

endmodule
